// File: rtl/shift_sequencer.sv
// shift_sequencer: register front/back end around the 4-bit barrel shifter.
// Captures an operand and command on a start edge. Drives the shifter from
// registers. Collects one or four shifter results into a 16-bit packed word.
module shift_sequencer #(
    parameter int unsigned SWEEP_STEPS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        start,
    input  logic        mode,
    input  logic [3:0]  din,
    input  logic [1:0]  shamt,
    output logic [3:0]  sh_i,
    output logic [1:0]  sh_s,
    input  logic [3:0]  sh_o,
    output logic [15:0] result,
    output logic        busy,
    output logic        done,
    output logic [7:0]  op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] LAST_STEP = 2'(SWEEP_STEPS - 1);

    state_t      state_q, state_d;
    logic        start_q;
    logic        mode_q, mode_d;
    logic [1:0]  step_q, step_d;
    logic [3:0]  sh_i_q, sh_i_d;
    logic [1:0]  sh_s_q, sh_s_d;
    logic [15:0] result_q, result_d;
    logic [7:0]  op_count_q, op_count_d;
    logic        accept;

    // A command is accepted only on a fresh rising edge of start while idle.
    assign accept = (state_q == IDLE) && start && !start_q;

    // Start history follows the pin even while ena is low. A start that rises
    // during a gated period and is still high afterwards therefore looks like a
    // level, not a new edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= 1'b0;
        end else begin
            start_q <= start;
        end
    end

    // Next-state, datapath and result packing for the sequencer.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        step_d     = step_q;
        sh_i_d     = sh_i_q;
        sh_s_d     = sh_s_q;
        result_d   = result_q;
        op_count_d = op_count_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = RUN;
                    sh_i_d   = din;
                    mode_d   = mode;
                    step_d   = '0;
                    sh_s_d   = mode ? 2'd0 : shamt;
                    result_d = '0;
                end
            end

            RUN: begin
                result_d[{step_q, 2'b00} +: 4] = sh_o;
                if (!mode_q || (step_q == LAST_STEP)) begin
                    state_d    = DONE;
                    op_count_d = op_count_q + 8'd1;
                end else begin
                    step_d = step_q + 2'd1;
                    sh_s_d = sh_s_q + 2'd1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; everything holds while ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mode_q     <= 1'b0;
            step_q     <= '0;
            sh_i_q     <= '0;
            sh_s_q     <= '0;
            result_q   <= '0;
            op_count_q <= '0;
        end else if (ena) begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            step_q     <= step_d;
            sh_i_q     <= sh_i_d;
            sh_s_q     <= sh_s_d;
            result_q   <= result_d;
            op_count_q <= op_count_d;
        end
    end

    assign sh_i     = sh_i_q;
    assign sh_s     = sh_s_q;
    assign result   = result_q;
    assign op_count = op_count_q;
    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);

endmodule
